// File: rtl/rs_ino_entries.sv
// ---------------------------------------------------------------------------
// rs_ino_entries
//   Entry storage for the in-order reservation station. Holds up to ENTNUM
//   dispatched instructions, snoops two writeback buses for operand wakeup,
//   squashes entries on a branch mispredict and clears speculative tags on a
//   correctly resolved branch.
//
// Optional build macro: RS_WAKEUP_BYPASS_EN
//   Defined   : readyvec and iss_src1/iss_src2 also see same-cycle wakeups.
//   Undefined : readyvec and iss_* come from registered state only.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   we1, we2, allocptr          write slot 1 at allocptr, slot 2 at allocptr+1
//   wr_payload1/2               payload per write slot
//   wr_src{1,2}_{1,2}           operand value, or rename tag when invalid
//   wr_vld{1,2}_{1,2}           operand valid per write slot
//   wr_spectag1/2               one-hot speculative tag per write slot
//   wb_en_x, wb_tag_x, wb_data_x  writeback buses a and b (a has priority)
//   issueptr, issue_fire        entry presented to execution / issue accepted
//   prmiss, prsuccess, prtag    branch resolution and its one-hot tag
//   busyvec                     registered busy bits
//   prbusyvec_next              busy bits after a squash by prtag (comb)
//   readyvec                    busy entries with both operands valid
//   iss_payload/src1/src2/spectag  contents of entry issueptr (comb)
// ---------------------------------------------------------------------------
module rs_ino_entries #(
  parameter int ENTSEL      = 2,
  parameter int ENTNUM      = 4,
  parameter int DATALEN     = 32,
  parameter int RRFSEL      = 6,
  parameter int PAYLOADLEN  = 16,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we1,
  input  logic                   we2,
  input  logic [ENTSEL-1:0]      allocptr,
  input  logic [PAYLOADLEN-1:0]  wr_payload1,
  input  logic [PAYLOADLEN-1:0]  wr_payload2,
  input  logic [DATALEN-1:0]     wr_src1_1,
  input  logic [DATALEN-1:0]     wr_src1_2,
  input  logic [DATALEN-1:0]     wr_src2_1,
  input  logic [DATALEN-1:0]     wr_src2_2,
  input  logic                   wr_vld1_1,
  input  logic                   wr_vld1_2,
  input  logic                   wr_vld2_1,
  input  logic                   wr_vld2_2,
  input  logic [SPECTAG_LEN-1:0] wr_spectag1,
  input  logic [SPECTAG_LEN-1:0] wr_spectag2,
  input  logic                   wb_en_a,
  input  logic                   wb_en_b,
  input  logic [RRFSEL-1:0]      wb_tag_a,
  input  logic [RRFSEL-1:0]      wb_tag_b,
  input  logic [DATALEN-1:0]     wb_data_a,
  input  logic [DATALEN-1:0]     wb_data_b,
  input  logic [ENTSEL-1:0]      issueptr,
  input  logic                   issue_fire,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic [ENTNUM-1:0]      busyvec,
  output logic [ENTNUM-1:0]      prbusyvec_next,
  output logic [ENTNUM-1:0]      readyvec,
  output logic [PAYLOADLEN-1:0]  iss_payload,
  output logic [DATALEN-1:0]     iss_src1,
  output logic [DATALEN-1:0]     iss_src2,
  output logic [SPECTAG_LEN-1:0] iss_spectag
);

  localparam logic [ENTSEL-1:0] IDX_ONE = ENTSEL'(1);

  // Entry state
  logic [ENTNUM-1:0]                  busy_q, busy_d;
  logic [ENTNUM-1:0]                  vld1_q, vld1_d;
  logic [ENTNUM-1:0]                  vld2_q, vld2_d;
  logic [ENTNUM-1:0][DATALEN-1:0]     src1_q, src1_d;
  logic [ENTNUM-1:0][DATALEN-1:0]     src2_q, src2_d;
  logic [ENTNUM-1:0][PAYLOADLEN-1:0]  payload_q, payload_d;
  logic [ENTNUM-1:0][SPECTAG_LEN-1:0] spectag_q, spectag_d;

  // Write-side and kill terms
  logic [ENTSEL-1:0]      alloc2_s;
  logic                   wr1_en_s;
  logic                   wr2_en_s;
  logic [DATALEN:0]       wr1_op1_s, wr1_op2_s, wr2_op1_s, wr2_op2_s;
  logic [SPECTAG_LEN-1:0] keep_mask_s;
  logic [ENTNUM-1:0]      iss_hit_s;
  logic [ENTNUM-1:0]      tag_hit_s;

  // Returns {valid, value} for an operand after looking at both writeback
  // buses; bus a wins when both carry the operand's tag.
  function automatic logic [DATALEN:0] snoop_f(input logic vld,
                                               input logic [DATALEN-1:0] src);
    logic [DATALEN:0] res;
    if (vld) begin
      res = {1'b1, src};
    end else if (wb_en_a && (src[RRFSEL-1:0] == wb_tag_a)) begin
      res = {1'b1, wb_data_a};
    end else if (wb_en_b && (src[RRFSEL-1:0] == wb_tag_b)) begin
      res = {1'b1, wb_data_b};
    end else begin
      res = {1'b0, src};
    end
    return res;
  endfunction

  // Write slot decode, write-time operand snoop and spectag keep-mask
  always_comb begin
    alloc2_s  = allocptr + IDX_ONE;
    wr1_en_s  = we1 & ~prmiss;
    wr2_en_s  = we2 & ~prmiss;
    wr1_op1_s = snoop_f(wr_vld1_1, wr_src1_1);
    wr1_op2_s = snoop_f(wr_vld2_1, wr_src2_1);
    wr2_op1_s = snoop_f(wr_vld1_2, wr_src1_2);
    wr2_op2_s = snoop_f(wr_vld2_2, wr_src2_2);
    // A mispredict overrides a simultaneous success: tags are then kept.
    if (prsuccess && !prmiss) begin
      keep_mask_s = ~prtag;
    end else begin
      keep_mask_s = {SPECTAG_LEN{1'b1}};
    end
  end

  // Per-entry issue/tag hits and the squash-preview busy vector
  always_comb begin
    iss_hit_s      = {ENTNUM{1'b0}};
    tag_hit_s      = {ENTNUM{1'b0}};
    prbusyvec_next = {ENTNUM{1'b0}};
    for (int i = 0; i < ENTNUM; i++) begin
      iss_hit_s[i]      = issue_fire && (issueptr == ENTSEL'(i));
      tag_hit_s[i]      = |(spectag_q[i] & prtag);
      prbusyvec_next[i] = busy_q[i] & ~tag_hit_s[i] & ~iss_hit_s[i];
    end
  end

  // Next state: wakeup, issue/squash kill, tag clearing, then writes on top
  always_comb begin
    busy_d    = busy_q;
    vld1_d    = vld1_q;
    vld2_d    = vld2_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    payload_d = payload_q;
    spectag_d = spectag_q;
    for (int i = 0; i < ENTNUM; i++) begin
      busy_d[i]    = busy_q[i] & ~iss_hit_s[i] & ~(prmiss & tag_hit_s[i]);
      spectag_d[i] = spectag_q[i] & keep_mask_s;
      if (busy_q[i]) begin
        {vld1_d[i], src1_d[i]} = snoop_f(vld1_q[i], src1_q[i]);
        {vld2_d[i], src2_d[i]} = snoop_f(vld2_q[i], src2_q[i]);
      end else begin
        {vld1_d[i], src1_d[i]} = {vld1_q[i], src1_q[i]};
        {vld2_d[i], src2_d[i]} = {vld2_q[i], src2_q[i]};
      end
      // A write overrides any kill of the same entry in this cycle.
      if (wr1_en_s && (allocptr == ENTSEL'(i))) begin
        busy_d[i]              = 1'b1;
        {vld1_d[i], src1_d[i]} = wr1_op1_s;
        {vld2_d[i], src2_d[i]} = wr1_op2_s;
        payload_d[i]           = wr_payload1;
        spectag_d[i]           = wr_spectag1 & keep_mask_s;
      end else if (wr2_en_s && (alloc2_s == ENTSEL'(i))) begin
        busy_d[i]              = 1'b1;
        {vld1_d[i], src1_d[i]} = wr2_op1_s;
        {vld2_d[i], src2_d[i]} = wr2_op2_s;
        payload_d[i]           = wr_payload2;
        spectag_d[i]           = wr_spectag2 & keep_mask_s;
      end else begin
        payload_d[i] = payload_q[i];
      end
    end
  end

  // Control state: busy, valid and spectag, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= {ENTNUM{1'b0}};
      vld1_q    <= {ENTNUM{1'b0}};
      vld2_q    <= {ENTNUM{1'b0}};
      spectag_q <= {(ENTNUM*SPECTAG_LEN){1'b0}};
    end else begin
      busy_q    <= busy_d;
      vld1_q    <= vld1_d;
      vld2_q    <= vld2_d;
      spectag_q <= spectag_d;
    end
  end

  // Data state: operands and payload, meaningless while the entry is idle
  always_ff @(posedge clk) begin
    src1_q    <= src1_d;
    src2_q    <= src2_d;
    payload_q <= payload_d;
  end

  assign busyvec     = busy_q;
  assign iss_payload = payload_q[issueptr];
  assign iss_spectag = spectag_q[issueptr];

`ifdef RS_WAKEUP_BYPASS_EN
  logic [ENTNUM-1:0][DATALEN:0] byp1_s, byp2_s;

  // Operand view including this cycle's writeback buses
  always_comb begin
    byp1_s   = {(ENTNUM*(DATALEN+1)){1'b0}};
    byp2_s   = {(ENTNUM*(DATALEN+1)){1'b0}};
    readyvec = {ENTNUM{1'b0}};
    for (int i = 0; i < ENTNUM; i++) begin
      byp1_s[i]   = snoop_f(vld1_q[i], src1_q[i]);
      byp2_s[i]   = snoop_f(vld2_q[i], src2_q[i]);
      readyvec[i] = busy_q[i] & byp1_s[i][DATALEN] & byp2_s[i][DATALEN];
    end
  end

  assign iss_src1 = byp1_s[issueptr][DATALEN-1:0];
  assign iss_src2 = byp2_s[issueptr][DATALEN-1:0];
`else
  assign readyvec = busy_q & vld1_q & vld2_q;
  assign iss_src1 = src1_q[issueptr];
  assign iss_src2 = src2_q[issueptr];
`endif

endmodule

// File: tb/tb_rs_ino_entries.sv
// Testbench for rs_ino_entries: directed scenarios followed by random
// traffic, all checked cycle by cycle against an entry-level reference model.
module tb_rs_ino_entries;
  localparam int ENTSEL      = 2;
  localparam int ENTNUM      = 4;
  localparam int DATALEN     = 32;
  localparam int RRFSEL      = 6;
  localparam int PAYLOADLEN  = 16;
  localparam int SPECTAG_LEN = 5;

  logic clk = 1'b0;
  logic reset, we1, we2, issue_fire, prmiss, prsuccess;
  logic [ENTSEL-1:0] allocptr, issueptr;
  logic [PAYLOADLEN-1:0] wr_payload1, wr_payload2;
  logic [DATALEN-1:0] wr_src1_1, wr_src1_2, wr_src2_1, wr_src2_2;
  logic wr_vld1_1, wr_vld1_2, wr_vld2_1, wr_vld2_2;
  logic [SPECTAG_LEN-1:0] wr_spectag1, wr_spectag2, prtag;
  logic wb_en_a, wb_en_b;
  logic [RRFSEL-1:0] wb_tag_a, wb_tag_b;
  logic [DATALEN-1:0] wb_data_a, wb_data_b;
  logic [ENTNUM-1:0] busyvec, prbusyvec_next, readyvec;
  logic [PAYLOADLEN-1:0] iss_payload;
  logic [DATALEN-1:0] iss_src1, iss_src2;
  logic [SPECTAG_LEN-1:0] iss_spectag;

  always #5 clk = ~clk;

  rs_ino_entries #(
    .ENTSEL(ENTSEL), .ENTNUM(ENTNUM), .DATALEN(DATALEN), .RRFSEL(RRFSEL),
    .PAYLOADLEN(PAYLOADLEN), .SPECTAG_LEN(SPECTAG_LEN)
  ) dut (
    .clk(clk), .reset(reset), .we1(we1), .we2(we2), .allocptr(allocptr),
    .wr_payload1(wr_payload1), .wr_payload2(wr_payload2),
    .wr_src1_1(wr_src1_1), .wr_src1_2(wr_src1_2),
    .wr_src2_1(wr_src2_1), .wr_src2_2(wr_src2_2),
    .wr_vld1_1(wr_vld1_1), .wr_vld1_2(wr_vld1_2),
    .wr_vld2_1(wr_vld2_1), .wr_vld2_2(wr_vld2_2),
    .wr_spectag1(wr_spectag1), .wr_spectag2(wr_spectag2),
    .wb_en_a(wb_en_a), .wb_en_b(wb_en_b), .wb_tag_a(wb_tag_a), .wb_tag_b(wb_tag_b),
    .wb_data_a(wb_data_a), .wb_data_b(wb_data_b),
    .issueptr(issueptr), .issue_fire(issue_fire),
    .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
    .busyvec(busyvec), .prbusyvec_next(prbusyvec_next), .readyvec(readyvec),
    .iss_payload(iss_payload), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_spectag(iss_spectag)
  );

  typedef struct {
    bit busy;
    bit v1;
    bit v2;
    logic [DATALEN-1:0] s1;
    logic [DATALEN-1:0] s2;
    logic [PAYLOADLEN-1:0] pay;
    logic [SPECTAG_LEN-1:0] tag;
  } ent_t;

  ent_t mdl [ENTNUM];
  ent_t mdl_nx [ENTNUM];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Operand availability given the writeback buses currently driven.
  function automatic bit bus_hit(input bit v, input logic [DATALEN-1:0] s,
                                 output logic [DATALEN-1:0] d);
    d = s;
    if (v) return 1'b1;
    if (wb_en_a && s[RRFSEL-1:0] == wb_tag_a) begin d = wb_data_a; return 1'b1; end
    if (wb_en_b && s[RRFSEL-1:0] == wb_tag_b) begin d = wb_data_b; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic ent_t new_ent(input logic [PAYLOADLEN-1:0] pay,
                                   input bit v1, input logic [DATALEN-1:0] s1,
                                   input bit v2, input logic [DATALEN-1:0] s2,
                                   input logic [SPECTAG_LEN-1:0] tag);
    ent_t e;
    logic [DATALEN-1:0] d;
    e.busy = 1'b1;
    e.v1 = bus_hit(v1, s1, d);
    e.s1 = d;
    e.v2 = bus_hit(v2, s2, d);
    e.s2 = d;
    e.pay = pay;
    e.tag = prsuccess ? (tag & ~prtag) : tag;
    return e;
  endfunction

  task automatic model_step();
    logic [DATALEN-1:0] d;
    logic [ENTSEL-1:0] a2;
    a2 = allocptr + 2'd1;
    for (int i = 0; i < ENTNUM; i++) mdl_nx[i] = mdl[i];
    if (reset) begin
      for (int i = 0; i < ENTNUM; i++) begin
        mdl_nx[i].busy = 1'b0;
        mdl_nx[i].v1 = 1'b0;
        mdl_nx[i].v2 = 1'b0;
        mdl_nx[i].tag = 5'd0;
      end
    end else begin
      for (int i = 0; i < ENTNUM; i++) begin
        if (mdl[i].busy) begin
          if (bus_hit(mdl[i].v1, mdl[i].s1, d)) begin mdl_nx[i].v1 = 1'b1; mdl_nx[i].s1 = d; end
          if (bus_hit(mdl[i].v2, mdl[i].s2, d)) begin mdl_nx[i].v2 = 1'b1; mdl_nx[i].s2 = d; end
        end
      end
      if (issue_fire) mdl_nx[issueptr].busy = 1'b0;
      if (prmiss) begin
        for (int i = 0; i < ENTNUM; i++)
          if ((mdl[i].tag & prtag) != 5'd0) mdl_nx[i].busy = 1'b0;
      end else begin
        if (prsuccess)
          for (int i = 0; i < ENTNUM; i++) mdl_nx[i].tag = mdl[i].tag & ~prtag;
        if (we1) mdl_nx[allocptr] = new_ent(wr_payload1, wr_vld1_1, wr_src1_1,
                                            wr_vld2_1, wr_src2_1, wr_spectag1);
        if (we2) mdl_nx[a2] = new_ent(wr_payload2, wr_vld1_2, wr_src1_2,
                                      wr_vld2_2, wr_src2_2, wr_spectag2);
      end
    end
  endtask

  task automatic check_outputs();
    logic [ENTNUM-1:0] eb, er, ep;
    logic [DATALEN-1:0] d1, d2;
    logic [ENTSEL-1:0] a2;
    bit r1, r2;
    for (int i = 0; i < ENTNUM; i++) begin
      eb[i] = mdl[i].busy;
`ifdef RS_WAKEUP_BYPASS_EN
      r1 = bus_hit(mdl[i].v1, mdl[i].s1, d1);
      r2 = bus_hit(mdl[i].v2, mdl[i].s2, d2);
`else
      r1 = mdl[i].v1;
      r2 = mdl[i].v2;
`endif
      er[i] = mdl[i].busy & r1 & r2;
      ep[i] = mdl[i].busy && ((mdl[i].tag & prtag) == 5'd0) &&
              !(issue_fire && issueptr == 2'(i));
    end
    chk("busyvec", 64'(busyvec), 64'(eb));
    chk("readyvec", 64'(readyvec), 64'(er));
    chk("prbusyvec_next", 64'(prbusyvec_next), 64'(ep));
    if (mdl[issueptr].busy) begin
`ifdef RS_WAKEUP_BYPASS_EN
      r1 = bus_hit(mdl[issueptr].v1, mdl[issueptr].s1, d1);
      r2 = bus_hit(mdl[issueptr].v2, mdl[issueptr].s2, d2);
`else
      d1 = mdl[issueptr].s1;
      d2 = mdl[issueptr].s2;
`endif
      chk("iss_payload", 64'(iss_payload), 64'(mdl[issueptr].pay));
      chk("iss_src1", 64'(iss_src1), 64'(d1));
      chk("iss_src2", 64'(iss_src2), 64'(d2));
      chk("iss_spectag", 64'(iss_spectag), 64'(mdl[issueptr].tag));
    end
    // Writing a busy entry is illegal stimulus.
    a2 = allocptr + 2'd1;
    if (!reset && !prmiss && we1) chk("wr1_target_idle", 64'(busyvec[allocptr]), 64'd0);
    if (!reset && !prmiss && we2) chk("wr2_target_idle", 64'(busyvec[a2]), 64'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    for (int i = 0; i < ENTNUM; i++) mdl[i] = mdl_nx[i];
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; we1 = 1'b0; we2 = 1'b0; allocptr = 2'd0;
    wr_payload1 = 16'd0; wr_payload2 = 16'd0;
    wr_src1_1 = 32'd0; wr_src1_2 = 32'd0; wr_src2_1 = 32'd0; wr_src2_2 = 32'd0;
    wr_vld1_1 = 1'b1; wr_vld1_2 = 1'b1; wr_vld2_1 = 1'b1; wr_vld2_2 = 1'b1;
    wr_spectag1 = 5'd0; wr_spectag2 = 5'd0;
    wb_en_a = 1'b0; wb_en_b = 1'b0; wb_tag_a = 6'd0; wb_tag_b = 6'd0;
    wb_data_a = 32'd0; wb_data_b = 32'd0;
    issueptr = 2'd0; issue_fire = 1'b0;
    prmiss = 1'b0; prsuccess = 1'b0; prtag = 5'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rand_op(output logic v, output logic [DATALEN-1:0] s);
    logic [DATALEN-1:0] r;
    v = 1'($urandom_range(0, 1));
    r = $urandom();
    if (!v) r[RRFSEL-1:0] = 6'($urandom_range(0, 7));
    s = r;
  endtask

  function automatic logic [SPECTAG_LEN-1:0] rand_tag();
    int unsigned k;
    logic [SPECTAG_LEN-1:0] one;
    k = $urandom_range(0, 5);
    one = 5'd1;
    if (k == 5) return 5'd0;
    return one << k;
  endfunction

  initial begin
    logic [ENTSEL-1:0] a2;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < ENTNUM; i++) begin
      mdl[i].busy = 1'b0; mdl[i].v1 = 1'b0; mdl[i].v2 = 1'b0;
      mdl[i].s1 = 32'd0; mdl[i].s2 = 32'd0; mdl[i].pay = 16'd0; mdl[i].tag = 5'd0;
    end
    clear_inputs();
    #1;
    chk("reset_busyvec", 64'(busyvec), 64'd0);
    chk("reset_readyvec", 64'(readyvec), 64'd0);
    chk("reset_prbusyvec", 64'(prbusyvec_next), 64'd0);

    // Dual write wrapping from entry 3 to entry 0
    we1 = 1'b1; we2 = 1'b1; allocptr = 2'd3;
    wr_src1_1 = 32'h11111111; wr_src2_1 = 32'h22222222;
    wr_src1_2 = 32'h33333333; wr_src2_2 = 32'h44444444;
    wr_payload1 = 16'h0A01; wr_payload2 = 16'h0A02;
    tick();
    clear_inputs();
    #1;
    chk("wrap_busyvec", 64'(busyvec), 64'h9);
    chk("wrap_readyvec", 64'(readyvec), 64'h9);
    tick();

    // Wakeup of an invalid operand from bus a
    do_reset();
    clear_inputs();
    we1 = 1'b1; allocptr = 2'd0; wr_vld1_1 = 1'b0; wr_src1_1 = 32'h00000012;
    wr_src2_1 = 32'h5555AAAA; wr_payload1 = 16'h0B00;
    tick();
    clear_inputs();
    tick();
    clear_inputs();
    wb_en_a = 1'b1; wb_tag_a = 6'h12; wb_data_a = 32'hDEADBEEF;
    #1;
`ifdef RS_WAKEUP_BYPASS_EN
    chk("wake_same_cycle_ready", 64'(readyvec[0]), 64'd1);
`else
    chk("wake_same_cycle_ready", 64'(readyvec[0]), 64'd0);
`endif
    tick();
    clear_inputs();
    #1;
    chk("wake_next_ready", 64'(readyvec[0]), 64'd1);
    chk("wake_iss_src1", 64'(iss_src1), 64'hDEADBEEF);
    tick();

    // Mispredict squash with a write that must be ignored
    do_reset();
    clear_inputs();
    we1 = 1'b1; we2 = 1'b1; allocptr = 2'd0;
    wr_payload1 = 16'h1000; wr_payload2 = 16'h1001;
    wr_spectag1 = 5'b00001; wr_spectag2 = 5'b00010;
    tick();
    clear_inputs();
    we1 = 1'b1; we2 = 1'b1; allocptr = 2'd2;
    wr_payload1 = 16'h1002; wr_payload2 = 16'h1003;
    wr_spectag1 = 5'b00010; wr_spectag2 = 5'b00000;
    tick();
    clear_inputs();
    prmiss = 1'b1; prtag = 5'b00010; we1 = 1'b1; allocptr = 2'd0; wr_payload1 = 16'hFFFF;
    #1;
    chk("miss_prbusyvec", 64'(prbusyvec_next), 64'h9);
    tick();
    clear_inputs();
    #1;
    chk("miss_busyvec", 64'(busyvec), 64'h9);
    chk("miss_no_write", 64'(iss_payload), 64'h1000);

    // Branch success clears the tag; later miss on that tag spares entry 0
    prsuccess = 1'b1; prtag = 5'b00001;
    tick();
    clear_inputs();
    #1;
    chk("success_spectag", 64'(iss_spectag), 64'd0);
    prmiss = 1'b1; prtag = 5'b00001;
    tick();
    clear_inputs();
    #1;
    chk("success_then_miss_busy", 64'(busyvec), 64'h9);
    tick();

    // Issue of a ready entry
    do_reset();
    clear_inputs();
    we1 = 1'b1; we2 = 1'b1; allocptr = 2'd2;
    wr_payload1 = 16'hA5C3; wr_payload2 = 16'h3C5A;
    tick();
    clear_inputs();
    issue_fire = 1'b1; issueptr = 2'd2;
    #1;
    chk("issue_payload", 64'(iss_payload), 64'hA5C3);
    chk("issue_ready", 64'(readyvec[2]), 64'd1);
    tick();
    clear_inputs();
    #1;
    chk("issue_busyvec", 64'(busyvec), 64'h8);
    tick();

    // Write-time snoop of both operands from bus b
    do_reset();
    clear_inputs();
    we1 = 1'b1; allocptr = 2'd1; wr_vld1_1 = 1'b0; wr_vld2_1 = 1'b0;
    wr_src1_1 = 32'h00000005; wr_src2_1 = 32'h00000005;
    wb_en_b = 1'b1; wb_tag_b = 6'h05; wb_data_b = 32'h0BADF00D;
    tick();
    clear_inputs();
    issueptr = 2'd1;
    #1;
    chk("snoop_readyvec", 64'(readyvec), 64'h2);
    chk("snoop_src1", 64'(iss_src1), 64'h0BADF00D);
    chk("snoop_src2", 64'(iss_src2), 64'h0BADF00D);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      reset = ($urandom_range(0, 99) == 0);
      wb_en_a = 1'($urandom_range(0, 1));
      wb_tag_a = 6'($urandom_range(0, 7));
      wb_data_a = $urandom();
      wb_en_b = 1'($urandom_range(0, 1));
      wb_tag_b = 6'($urandom_range(0, 7));
      wb_data_b = $urandom();
      prmiss = ($urandom_range(0, 9) == 0);
      prsuccess = ($urandom_range(0, 7) == 0);
      prtag = rand_tag();
      if (prtag == 5'd0) prtag = 5'b00100;
      allocptr = 2'($urandom_range(0, 3));
      a2 = allocptr + 2'd1;
      if (!mdl[allocptr].busy && $urandom_range(0, 9) < 7) begin
        we1 = 1'b1;
        rand_op(wr_vld1_1, wr_src1_1);
        rand_op(wr_vld2_1, wr_src2_1);
        wr_payload1 = 16'($urandom());
        wr_spectag1 = rand_tag();
        if (!mdl[a2].busy && $urandom_range(0, 1) == 1) begin
          we2 = 1'b1;
          rand_op(wr_vld1_2, wr_src1_2);
          rand_op(wr_vld2_2, wr_src2_2);
          wr_payload2 = 16'($urandom());
          wr_spectag2 = rand_tag();
        end
      end
      issueptr = 2'($urandom_range(0, 3));
      issue_fire = ($urandom_range(0, 9) < 4);
      if (issue_fire && ((we1 && issueptr == allocptr) || (we2 && issueptr == a2)))
        issue_fire = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_ino_entries.md
Name: rs_ino_entries

Overview:
- Entry storage for the in-order reservation station. It holds up to ENTNUM dispatched instructions and snoops the writeback buses for operand wakeup.
- Exports busyvec, prbusyvec_next and readyvec to the alloc/issue pointer logic.
- Takes allocptr and issueptr back from that logic. Presents the operands and payload at issueptr to the execution unit.
- Handles branch-miss squash and branch-success tag clearing using one-hot spectags.

Parameters:
ENTSEL, 2, entry index width
ENTNUM, 4, number of entries (= 2**ENTSEL)
DATALEN, 32, operand width
RRFSEL, 6, rename-register tag width (tag held in src[RRFSEL-1:0] while operand invalid)
PAYLOADLEN, 16, opaque decoded-instruction payload width
SPECTAG_LEN, 5, one-hot speculative tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
we1  in  1  write slot 1 at allocptr
we2  in  1  write slot 2 at allocptr+1 (mod ENTNUM)
allocptr  in  ENTSEL  base write index
wr_payload1/2  in  PAYLOADLEN  payload per slot
wr_src1_1/2, wr_src2_1/2  in  DATALEN  operand value, or tag if invalid
wr_vld1_1/2, wr_vld2_1/2  in  1  operand valid
wr_spectag1/2  in  SPECTAG_LEN  speculative tag per slot
wb_en_a, wb_en_b  in  1  writeback bus valid
wb_tag_a, wb_tag_b  in  RRFSEL  writeback destination tag
wb_data_a, wb_data_b  in  DATALEN  writeback value
issueptr  in  ENTSEL  entry being issued
issue_fire  in  1  issue accepted this cycle
prmiss  in  1  branch mispredict
prsuccess  in  1  branch resolved correct
prtag  in  SPECTAG_LEN  one-hot tag of resolving branch
busyvec  out  ENTNUM  registered busy bits
prbusyvec_next  out  ENTNUM  next busy bits under miss squash (combinational)
readyvec  out  ENTNUM  busy & both operands valid
iss_payload  out  PAYLOADLEN  payload at issueptr (combinational)
iss_src1, iss_src2  out  DATALEN  operands at issueptr (combinational)
iss_spectag  out  SPECTAG_LEN  spectag at issueptr

Behaviour:
- Reset: busy, valid bits and spectags of all entries cleared. busyvec = readyvec = prbusyvec_next = 0. Data and payload registers are don't-care.
- Write, one cycle latency:
  - we1 loads entry allocptr; we2 loads entry (allocptr+1) mod ENTNUM; the index wraps naturally in ENTSEL bits.
  - The written entry becomes busy=1 next cycle.
  - we2 without we1 is illegal. Writing a busy entry is illegal; the bench flags it.
- Write-time snoop:
  - An incoming invalid operand whose tag matches an enabled wb bus this cycle is stored with that bus data and valid=1.
  - Bus a has priority over bus b on equal tags.
- Wakeup:
  - Every busy entry with an invalid operand whose src[RRFSEL-1:0] equals wb_tag_x with wb_en_x=1 captures wb_data_x and sets valid=1 next cycle.
  - Both operands of one entry may wake in the same cycle, from the same or different buses.
- readyvec[i] = busy[i] & vld1[i] & vld2[i], from registered state only.
- Issue:
  - iss_* read entry issueptr combinationally.
  - issue_fire clears busy[issueptr] next cycle.
  - issue_fire on a non-busy entry is ignored.
- Mispredict (prmiss=1):
  - Entries with (spectag & prtag) != 0 have busy cleared.
  - we1/we2 are ignored that cycle.
  - issue_fire still clears its entry; upstream logic suppresses issue on prmiss, but the storage must tolerate it.
- prbusyvec_next[i] = busy[i] & ~((spectag[i] & prtag) != 0) & ~(issue_fire & issueptr==i). It is driven irrespective of prmiss.
- Branch success (prsuccess=1): every entry does spectag <= spectag & ~prtag. This applies to the incoming write spectags too. prsuccess and prmiss together: prmiss wins.
- Same cycle write to entry i and issue of entry i: impossible by construction. The write wins.
- Reset asserted mid-operation clears all state next edge, regardless of other inputs.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined:
  - readyvec also counts a same-cycle wakeup as valid.
  - iss_src1/iss_src2 forward wb_data of a matching enabled bus when the stored operand is invalid.
  - Issue is one cycle earlier after wakeup.
- Undefined: readyvec and iss_* use registered state only. An entry woken in cycle N is first ready in cycle N+1.

Test Plan:
- Reset, then we1=we2=1 with allocptr=3, all operands valid, spectag=0 -> next cycle busyvec=4'b1001 and readyvec=4'b1001.
- Write entry 0 with wr_vld1_1=0 and wr_src1_1=tag 6'h12; two cycles later wb_en_a=1, wb_tag_a=6'h12, wb_data_a=32'hDEADBEEF -> next cycle readyvec[0]=1, iss_src1=32'hDEADBEEF at issueptr=0. With RS_WAKEUP_BYPASS_EN, readyvec[0]=1 in the wakeup cycle itself.
- Entries 0-3 busy with spectags 5'b00001, 5'b00010, 5'b00010, 0; prmiss=1, prtag=5'b00010, we1=1 -> prbusyvec_next=4'b1001 in that cycle, busyvec=4'b1001 next cycle, and no entry is written.
- prsuccess=1, prtag=5'b00001 with entry 0 spectag 5'b00001 -> entry 0 spectag=0. A following prmiss with prtag=5'b00001 leaves busy[0]=1.
- Entry 2 ready, issue_fire=1, issueptr=2 -> iss_payload equals the written payload, and busy[2]=0 next cycle.
- Write entry 1 with both operands invalid, tags 6'h05 and 6'h05, while wb_en_b=1, wb_tag_b=6'h05 in the same cycle -> entry 1 written with both operands valid and equal to wb_data_b; readyvec[1]=1 next cycle.
